inst_rom_banked: RTL and testbench

Parametrised successor to the fixed instruction ROM. It holds BANKS independent program images of 2**A words, each W bits wide. Reads are synchronous, with a registered fetch port for the fetch stage. A handshaked loader port writes program images at runtime, so new programs can be loaded without recompiling or re-reading a file. It sits between the program counter and the decoder, and the testbench or host loader drives the load port.

---
 rtl/inst_rom_banked.sv | 162 ++++++++++++++++
 tb/tb_inst_rom_banked.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_banked.sv
// Banked instruction memory: BANKS program images of 2**A words, W bits each.
// Registered fetch port (1-cycle latency, read-before-write on collision) and a
// handshaked loader that writes a program image at runtime.
// Optional macro INST_ROM_PARITY_EN adds one even-parity bit per stored word
// and a registered ParityErr flag; without it ParityErr is tied low.
module inst_rom_banked #(
    parameter int A     = 10,
    parameter int W     = 9,
    parameter int BANKS = 4,
    localparam int BB   = $clog2(BANKS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          FetchReq,
    input  logic [BB-1:0] FetchBank,
    input  logic [A-1:0]  FetchAddr,
    output logic          FetchValid,
    output logic [W-1:0]  InstOut,
    output logic          ParityErr,
    input  logic          LoadStart,
    input  logic [BB-1:0] LoadBank,
    input  logic [A-1:0]  LoadBase,
    input  logic [A:0]    LoadLen,
    input  logic          LoadValid,
    input  logic [W-1:0]  LoadData,
    output logic          LoadReady,
    output logic          LoadDone,
    output logic          LoadBusy
);

`ifdef INST_ROM_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif
    localparam int DEPTH = BANKS * (2 ** A);
    localparam logic [W-1:0] ONES = '1;
`ifdef INST_ROM_PARITY_EN
    localparam logic [MW-1:0] INIT_WORD = {^ONES, ONES};
`else
    localparam logic [MW-1:0] INIT_WORD = ONES;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } load_state_t;

    load_state_t state, state_next;

    // Banks are flattened into one array indexed by {bank, address}; every
    // word powers up as the all-ones halt instruction.
    logic [MW-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [BB-1:0] load_bank;
    logic [A-1:0]  ptr;
    logic [A:0]    count;
    logic [A:0]    len;
    logic          accept;
    logic          last_word;
    logic [MW-1:0] rd_word;
    logic [MW-1:0] wr_word;

    assign accept    = (state == LOAD) && LoadValid;
    assign last_word = (count + (A + 1)'(1)) == len;
    assign rd_word   = mem[{FetchBank, FetchAddr}];
`ifdef INST_ROM_PARITY_EN
    assign wr_word   = {^LoadData, LoadData};
`else
    assign wr_word   = LoadData;
`endif

    // Loader write port; reset in the same cycle suppresses the write.
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            mem[{load_bank, ptr}] <= wr_word;
        end
    end

    // Fetch pipeline register; outputs hold when no request is made.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchValid <= 1'b0;
            InstOut    <= '0;
        end else begin
            FetchValid <= FetchReq;
            if (FetchReq) begin
                InstOut <= rd_word[W-1:0];
            end
        end
    end

`ifdef INST_ROM_PARITY_EN
    // Stored parity xor recomputed parity equals the xor of the whole word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ParityErr <= 1'b0;
        end else if (FetchReq) begin
            ParityErr <= ^rd_word;
        end
    end
`else
    assign ParityErr = 1'b0;
`endif

    // Loader state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loader next-state and handshake outputs.
    always_comb begin
        state_next = state;
        LoadReady  = 1'b0;
        LoadDone   = 1'b0;
        LoadBusy   = 1'b0;
        case (state)
            IDLE: begin
                if (LoadStart) begin
                    state_next = (LoadLen == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                LoadReady = 1'b1;
                LoadBusy  = 1'b1;
                if (accept && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                LoadDone   = 1'b1;
                LoadBusy   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load descriptor capture, write pointer (wraps inside the bank) and count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            load_bank <= '0;
            ptr       <= '0;
            count     <= '0;
            len       <= '0;
        end else if (state == IDLE && LoadStart) begin
            load_bank <= LoadBank;
            ptr       <= LoadBase;
            len       <= LoadLen;
            count     <= '0;
        end else if (accept) begin
            ptr   <= ptr + A'(1);
            count <= count + (A + 1)'(1);
        end
    end

endmodule

// File: tb/tb_inst_rom_banked.sv
// Self-checking bench for inst_rom_banked. A flat array model of all banks is
// updated from the loader rules (len words written at base+i modulo bank size)
// and every fetch is compared against it. Compile with INST_ROM_PARITY_EN to
// exercise the parity path.
module tb_inst_rom_banked;
    localparam int A     = 10;
    localparam int W     = 9;
    localparam int BANKS = 4;
    localparam int BB    = 2;
    localparam int DEPTH = 2 ** A;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          FetchReq = 1'b0;
    logic [BB-1:0] FetchBank = '0;
    logic [A-1:0]  FetchAddr = '0;
    logic          FetchValid;
    logic [W-1:0]  InstOut;
    logic          ParityErr;
    logic          LoadStart = 1'b0;
    logic [BB-1:0] LoadBank = '0;
    logic [A-1:0]  LoadBase = '0;
    logic [A:0]    LoadLen = '0;
    logic          LoadValid = 1'b0;
    logic [W-1:0]  LoadData = '0;
    logic          LoadReady;
    logic          LoadDone;
    logic          LoadBusy;

    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] model [BANKS*DEPTH];
    logic [W-1:0] words [$];

    inst_rom_banked #(.A(A), .W(W), .BANKS(BANKS)) dut (
        .Clk(Clk), .Reset(Reset),
        .FetchReq(FetchReq), .FetchBank(FetchBank), .FetchAddr(FetchAddr),
        .FetchValid(FetchValid), .InstOut(InstOut), .ParityErr(ParityErr),
        .LoadStart(LoadStart), .LoadBank(LoadBank), .LoadBase(LoadBase),
        .LoadLen(LoadLen), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadReady(LoadReady), .LoadDone(LoadDone), .LoadBusy(LoadBusy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int mi(input int b, input int a);
        return b * DEPTH + (a % DEPTH);
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic fetch(input int b, input int a);
        FetchReq  = 1'b1;
        FetchBank = BB'(b);
        FetchAddr = A'(a % DEPTH);
        tick;
        FetchReq  = 1'b0;
    endtask

    // Host-side loader driver: mode 0 continuous valid, 1 alternating, 2 random.
    task automatic run_load(input int b, input int base, input int len, input int mode,
                            output int ready_cnt, output int done_cnt,
                            output int done_cyc, output int sent);
        logic v, acc;
        LoadBank  = BB'(b);
        LoadBase  = A'(base);
        LoadLen   = (A + 1)'(len);
        LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        sent = 0; ready_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 4 * len + 16; cyc++) begin
            if (LoadDone) begin
                done_cnt++;
                done_cyc = cyc;
                LoadValid = 1'b0;
                tick;
                if (LoadDone) done_cnt++;
                break;
            end
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            LoadValid = v;
            LoadData  = (v && sent < len) ? words[sent] : W'($urandom);
            if (LoadReady) ready_cnt++;
            acc = v && LoadReady;
            tick;
            if (acc) sent++;
        end
        LoadValid = 1'b0;
        for (int i = 0; i < len; i++) model[mi(b, base + i)] = words[i];
    endtask

    task automatic test_reset;
        Reset = 1'b1; FetchReq = 1'b1; LoadStart = 1'b1; LoadLen = 11'd3;
        tick; tick;
        n_cmp++; if (FetchValid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_fetchvalid: got %b want 0", FetchValid); end
        n_cmp++; if (InstOut !== 9'h000) begin n_fail++; $display("[TB] FAIL rst_instout: got %h want 000", InstOut); end
        n_cmp++; if (ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_parity: got %b want 0", ParityErr); end
        n_cmp++; if (LoadReady !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b want 0", LoadReady); end
        n_cmp++; if (LoadDone !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b want 0", LoadDone); end
        n_cmp++; if (LoadBusy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", LoadBusy); end
        Reset = 1'b0; FetchReq = 1'b0; LoadStart = 1'b0; LoadLen = '0;
        tick;
        n_cmp++; if (LoadBusy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after_busy: got %b want 0", LoadBusy); end
        fetch(0, 5);
        n_cmp++; if (FetchValid !== 1'b1) begin n_fail++; $display("[TB] FAIL init_valid: got %b want 1", FetchValid); end
        n_cmp++; if (InstOut !== model[mi(0, 5)]) begin n_fail++; $display("[TB] FAIL init_word: got %h want %h", InstOut, model[mi(0, 5)]); end
        n_cmp++; if (ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL init_parity: got %b want 0", ParityErr); end
    endtask

    task automatic test_load_basic;
        int rc, dc, dcyc, sent;
        words = '{9'h00C, 9'h0A8, 9'h0CC};
        run_load(2, 0, 3, 0, rc, dc, dcyc, sent);
        n_cmp++; if (rc !== 3) begin n_fail++; $display("[TB] FAIL basic_ready_cycles: got %0d want 3", rc); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", dc); end
        n_cmp++; if (dcyc !== 3) begin n_fail++; $display("[TB] FAIL basic_done_cycle: got %0d want 3", dcyc); end
        n_cmp++; if (LoadBusy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_after: got %b want 0", LoadBusy); end
        FetchReq = 1'b1; FetchBank = 2'd2;
        for (int i = 0; i < 3; i++) begin
            FetchAddr = A'(i);
            tick;
            n_cmp++; if (FetchValid !== 1'b1 || InstOut !== model[mi(2, i)]) begin n_fail++; $display("[TB] FAIL basic_b2b[%0d]: got %b/%h want 1/%h", i, FetchValid, InstOut, model[mi(2, i)]); end
        end
        FetchReq = 1'b0;
        tick;
        n_cmp++; if (FetchValid !== 1'b0 || InstOut !== model[mi(2, 2)]) begin n_fail++; $display("[TB] FAIL basic_hold: got %b/%h want 0/%h", FetchValid, InstOut, model[mi(2, 2)]); end
    endtask

    task automatic test_load_wrap;
        int rc, dc, dcyc, sent;
        words = '{9'h011, 9'h022};
        run_load(1, 1023, 2, 1, rc, dc, dcyc, sent);
        n_cmp++; if (rc !== 3) begin n_fail++; $display("[TB] FAIL wrap_ready_cycles: got %0d want 3", rc); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("[TB] FAIL wrap_done_pulses: got %0d want 1", dc); end
        foreach (words[i]) begin end
        for (int i = 0; i < 3; i++) begin
            int a;
            a = (i == 0) ? 1023 : i - 1;
            fetch(1, a);
            n_cmp++; if (InstOut !== model[mi(1, a)] || ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_word[%0d]: got %h/%b want %h/0", a, InstOut, ParityErr, model[mi(1, a)]); end
        end
    endtask

    task automatic test_rw_collision;
        logic [W-1:0] old_word;
        LoadBank = 2'd3; LoadBase = 10'd7; LoadLen = 11'd1; LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        n_cmp++; if (LoadReady !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_ready: got %b want 1", LoadReady); end
        old_word = model[mi(3, 7)];
        LoadValid = 1'b1; LoadData = 9'h055;
        FetchReq = 1'b1; FetchBank = 2'd3; FetchAddr = 10'd7;
        tick;
        LoadValid = 1'b0;
        model[mi(3, 7)] = 9'h055;
        n_cmp++; if (InstOut !== old_word) begin n_fail++; $display("[TB] FAIL coll_old_word: got %h want %h", InstOut, old_word); end
        n_cmp++; if (LoadDone !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_done: got %b want 1", LoadDone); end
        tick;
        n_cmp++; if (InstOut !== model[mi(3, 7)]) begin n_fail++; $display("[TB] FAIL coll_new_word: got %h want %h", InstOut, model[mi(3, 7)]); end
        FetchReq = 1'b0;
        tick;
    endtask

    task automatic test_reset_midload;
        int done_seen;
        LoadBank = 2'd0; LoadBase = 10'd0; LoadLen = 11'd4; LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        LoadValid = 1'b1; LoadData = 9'h001; tick;
        LoadData = 9'h002; tick;
        LoadData = 9'h003; Reset = 1'b1; tick;
        Reset = 1'b0; LoadValid = 1'b0;
        model[mi(0, 0)] = 9'h001;
        model[mi(0, 1)] = 9'h002;
        n_cmp++; if (LoadBusy !== 1'b0 || LoadReady !== 1'b0 || LoadDone !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_state: got busy=%b ready=%b done=%b want 0/0/0", LoadBusy, LoadReady, LoadDone); end
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin tick; if (LoadDone) done_seen++; end
        n_cmp++; if (done_seen !== 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
        for (int i = 0; i < 4; i++) begin
            fetch(0, i);
            n_cmp++; if (InstOut !== model[mi(0, i)]) begin n_fail++; $display("[TB] FAIL midrst_word[%0d]: got %h want %h", i, InstOut, model[mi(0, i)]); end
        end
    endtask

    task automatic test_zero_len;
        LoadBank = 2'd0; LoadBase = 10'd10; LoadLen = '0; LoadStart = 1'b1;
        LoadValid = 1'b1; LoadData = 9'h0AA;
        tick;
        LoadStart = 1'b0;
        n_cmp++; if (LoadDone !== 1'b1 || LoadReady !== 1'b0 || LoadBusy !== 1'b1) begin n_fail++; $display("[TB] FAIL zlen_done: got done=%b ready=%b busy=%b want 1/0/1", LoadDone, LoadReady, LoadBusy); end
        tick;
        LoadValid = 1'b0;
        n_cmp++; if (LoadDone !== 1'b0 || LoadBusy !== 1'b0) begin n_fail++; $display("[TB] FAIL zlen_idle: got done=%b busy=%b want 0/0", LoadDone, LoadBusy); end
        fetch(0, 10);
        n_cmp++; if (InstOut !== model[mi(0, 10)]) begin n_fail++; $display("[TB] FAIL zlen_nowrite: got %h want %h", InstOut, model[mi(0, 10)]); end
    endtask

    task automatic test_concurrent_fetch;
        int b, base, ob, oa;
        logic [W-1:0] exp;
        logic [W-1:0] wl [6];
        b = $urandom_range(0, 3);
        base = $urandom_range(0, DEPTH - 1);
        foreach (wl[i]) wl[i] = W'($urandom);
        LoadBank = BB'(b); LoadBase = A'(base); LoadLen = 11'd6; LoadStart = 1'b1;
        tick;
        LoadStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ob = (b + 1 + $urandom_range(0, 2)) % BANKS;
            oa = $urandom_range(0, DEPTH - 1);
            exp = model[mi(ob, oa)];
            LoadValid = 1'b1; LoadData = wl[i];
            FetchReq = 1'b1; FetchBank = BB'(ob); FetchAddr = A'(oa);
            tick;
            n_cmp++; if (FetchValid !== 1'b1 || InstOut !== exp) begin n_fail++; $display("[TB] FAIL conc_other_bank[%0d]: got %b/%h want 1/%h", i, FetchValid, InstOut, exp); end
        end
        LoadValid = 1'b0; FetchReq = 1'b0;
        for (int i = 0; i < 6; i++) model[mi(b, base + i)] = wl[i];
        n_cmp++; if (LoadDone !== 1'b1) begin n_fail++; $display("[TB] FAIL conc_done: got %b want 1", LoadDone); end
        tick;
        FetchReq = 1'b1; FetchBank = BB'(b);
        for (int i = 0; i < 6; i++) begin
            FetchAddr = A'((base + i) % DEPTH);
            tick;
            n_cmp++; if (InstOut !== model[mi(b, base + i)]) begin n_fail++; $display("[TB] FAIL conc_readback[%0d]: got %h want %h", i, InstOut, model[mi(b, base + i)]); end
        end
        FetchReq = 1'b0;
        tick;
    endtask

    task automatic test_random;
        int b, base, len, rc, dc, dcyc, sent, fb, fa;
        logic req;
        logic [W-1:0] last_exp;
        last_exp = '0;
        for (int it = 0; it < 12; it++) begin
            b = $urandom_range(0, 3);
            base = ($urandom_range(0, 2) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
            len = $urandom_range(1, 16);
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(W'($urandom));
            run_load(b, base, len, 2, rc, dc, dcyc, sent);
            n_cmp++; if (dc !== 1 || sent !== len) begin n_fail++; $display("[TB] FAIL rand_load[%0d]: got done=%0d sent=%0d want 1/%0d", it, dc, sent, len); end
            for (int k = 0; k < 8; k++) begin
                req = (k == 0) || ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin fb = b; fa = (base + $urandom_range(0, len - 1)) % DEPTH; end
                else begin fb = $urandom_range(0, 3); fa = $urandom_range(0, DEPTH - 1); end
                FetchReq = req; FetchBank = BB'(fb); FetchAddr = A'(fa);
                if (req) last_exp = model[mi(fb, fa)];
                tick;
                n_cmp++; if (FetchValid !== req || InstOut !== last_exp || ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_fetch[%0d.%0d]: got %b/%h/%b want %b/%h/0", it, k, FetchValid, InstOut, ParityErr, req, last_exp); end
            end
            FetchReq = 1'b0;
        end
    endtask

    task automatic test_parity;
`ifdef INST_ROM_PARITY_EN
        int rc, dc, dcyc, sent;
        words = '{9'h003};
        run_load(0, 20, 1, 0, rc, dc, dcyc, sent);
        fetch(0, 20);
        n_cmp++; if (InstOut !== 9'h003 || ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL par_clean: got %h/%b want 003/0", InstOut, ParityErr); end
        dut.mem[20][W] = ~dut.mem[20][W];
        fetch(0, 20);
        n_cmp++; if (FetchValid !== 1'b1 || ParityErr !== 1'b1) begin n_fail++; $display("[TB] FAIL par_flip: got valid=%b perr=%b want 1/1", FetchValid, ParityErr); end
        dut.mem[20][W] = ~dut.mem[20][W];
        fetch(0, 20);
        n_cmp++; if (ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL par_restore: got %b want 0", ParityErr); end
`else
        for (int i = 0; i < 4; i++) begin
            fetch($urandom_range(0, 3), $urandom_range(0, DEPTH - 1));
            n_cmp++; if (ParityErr !== 1'b0) begin n_fail++; $display("[TB] FAIL par_tied: got %b want 0", ParityErr); end
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < BANKS * DEPTH; i++) model[i] = '1;
        test_reset;
        test_load_basic;
        test_load_wrap;
        test_rw_collision;
        test_reset_midload;
        test_zero_len;
        test_concurrent_fetch;
        test_random;
        test_parity;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
